// File: rtl/sobel_core.sv
// 3x3 Sobel edge engine on a raster pixel stream: two line buffers, a window
// register, then gradient and magnitude/threshold stages (3-cycle latency).
module sobel_core #(
  parameter int unsigned IMG_W  = 100,
  parameter int unsigned IMG_H  = 100,
  parameter int unsigned DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              frame_clr,
  input  logic              pi_flag,
  input  logic [DATA_W-1:0] pi_data,
  input  logic              mode,
  input  logic [DATA_W+3:0] thresh,
  output logic              po_flag,
  output logic [DATA_W-1:0] po_sum,
  output logic              po_eof
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned GW = DATA_W + 3;
  localparam int unsigned SW = DATA_W + 4;

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return signed'(GW'(p));
  endfunction

  function automatic logic [SW-1:0] mag(input logic signed [GW-1:0] g);
    logic [GW-1:0] u;
    u = g[GW-1] ? GW'(-g) : GW'(g);
    return SW'(u);
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic v1_q, v1_d, eof1_q, eof1_d;
  logic v2_q, v2_d, eof2_q, eof2_d;
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d, gx_c, gy_c;
  logic po_flag_q, po_flag_d, po_eof_q, po_eof_d;
  logic [DATA_W-1:0] po_sum_q, po_sum_d;
  logic [DATA_W-1:0] lb0_rd_c, lb1_rd_c;
  logic [SW-1:0] s_c;
  logic acc_c, win_valid_c, last_c;

  // A strobe coincident with a frame restart is discarded.
  assign acc_c       = pi_flag & ~frame_clr;
  assign win_valid_c = acc_c && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign last_c      = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
  assign lb0_rd_c    = lb0_mem[col_q];
  assign lb1_rd_c    = lb1_mem[col_q];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (pi_flag) begin
      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window columns enter on the right: oldest line on top, live pixel at bottom.
  always_comb begin
    win_d = win_q;
    if (acc_c) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd_c;
      win_d[1][2] = lb0_rd_c;
      win_d[2][2] = pi_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    win_q <= win_d;
    if (acc_c) begin
      lb0_mem[col_q] <= pi_data;
      lb1_mem[col_q] <= lb0_rd_c;
    end
  end

  assign gx_c = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
              - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
  assign gy_c = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
              - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
  assign s_c  = mag(gx_q) + mag(gy_q);

  always_comb begin
    v1_d      = win_valid_c;
    eof1_d    = last_c;
    v2_d      = v1_q & ~frame_clr;
    eof2_d    = eof1_q;
    gx_d      = v1_q ? gx_c : gx_q;
    gy_d      = v1_q ? gy_c : gy_q;
    po_flag_d = v2_q & ~frame_clr;
    po_eof_d  = v2_q & ~frame_clr & eof2_q;
    po_sum_d  = po_sum_q;
    if (po_flag_d) begin
      if (mode) begin
        po_sum_d = (s_c > SW'({DATA_W{1'b1}})) ? '1 : s_c[DATA_W-1:0];
      end else begin
        po_sum_d = (s_c >= thresh) ? '1 : '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      v1_q      <= 1'b0;
      eof1_q    <= 1'b0;
      v2_q      <= 1'b0;
      eof2_q    <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      po_flag_q <= 1'b0;
      po_eof_q  <= 1'b0;
      po_sum_q  <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      v1_q      <= v1_d;
      eof1_q    <= eof1_d;
      v2_q      <= v2_d;
      eof2_q    <= eof2_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      po_flag_q <= po_flag_d;
      po_eof_q  <= po_eof_d;
      po_sum_q  <= po_sum_d;
    end
  end

  assign po_flag = po_flag_q;
  assign po_sum  = po_sum_q;
  assign po_eof  = po_eof_q;

endmodule
